// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit driving a single-cycle word memory; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests complete with resp_fault and no memory access.
module mem_lsu #(
  parameter int AW = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_enable,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FLT} state_t;
  state_t state, nxt;
  logic we_r, uns_r, acc, mis;
  logic [1:0] sz_r, lane_r;
  logic [15:0] wd_r, hsel;
  logic [7:0] bsel;
  logic [31:0] ext, merged;
  logic resp_valid_d, resp_fault_d, mem_enable_d, mem_read_d;
  logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

  assign req_ready = state == IDLE;
  assign acc = req_valid && req_ready;
`ifdef MISALIGN_TRAP_EN
  assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      sz_r       <= 2'b00;
      lane_r     <= 2'b00;
      wd_r       <= 16'h0;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= 32'h0;
      mem_enable <= 1'b0;
      mem_read   <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      state      <= nxt;
      resp_valid <= resp_valid_d;
      resp_fault <= resp_fault_d;
      resp_rdata <= resp_rdata_d;
      mem_enable <= mem_enable_d;
      mem_read   <= mem_read_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if (acc) begin
        we_r   <= req_we;
        uns_r  <= req_unsigned;
        sz_r   <= req_size;
        lane_r <= req_addr[1:0];
        wd_r   <= req_wdata[15:0];
      end
    end
  end

  // Word stores skip the read; only byte/half stores pass through CAP on their way to WR.
  always_comb begin
    nxt = state == IDLE ? (!acc ? IDLE : mis ? FLT : (req_we && req_size[1]) ? WR : RD)
        : state == RD   ? CAP
        : state == CAP  ? (we_r ? WR : IDLE)
        : IDLE;
  end

  always_comb begin
    bsel   = mem_rdata[{lane_r, 3'b000} +: 8];
    hsel   = mem_rdata[{lane_r[1], 4'b0000} +: 16];
    ext    = sz_r[1] ? mem_rdata
           : sz_r[0] ? {{16{!uns_r && hsel[15]}}, hsel}
           : {{24{!uns_r && bsel[7]}}, bsel};
    merged = mem_rdata;
    if (sz_r[0]) merged[{lane_r[1], 4'b0000} +: 16] = wd_r;
    else merged[{lane_r, 3'b000} +: 8] = wd_r[7:0];
    mem_enable_d = nxt == RD || nxt == WR;
    mem_read_d   = nxt == RD;
    mem_addr_d   = acc ? {{(32-AW){1'b0}}, req_addr[AW+1:2]} : mem_addr;
    mem_wdata_d  = acc ? req_wdata : state == CAP ? merged : mem_wdata;
    resp_valid_d = (state == CAP && !we_r) || state == WR || state == FLT;
    resp_fault_d = state == FLT;
    resp_rdata_d = (state == CAP && !we_r) ? ext : 32'h0;
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed scoreboard bench for mem_lsu with a single-cycle word memory model.
module tb_mem_lsu;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, mem_rdata = 32'h0;
  logic req_ready, resp_valid, resp_fault, mem_enable, mem_read;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem [0:1023];
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, en_cnt = 0, checks = 0, fails = 0, last_acc = 0;
  typedef struct {logic [31:0] rd; logic f; int c;} exp_t;
  exp_t sbq[$];

  mem_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_enable(mem_enable), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      mem[256] <= 32'h88776655;
      mem[257] <= 32'h0;
    end else if (mem_enable) begin
      en_cnt <= en_cnt + 1;
      if (mem_read) begin
        mem_rdata <= mem[mem_addr[9:0]];
        rd_cnt <= rd_cnt + 1;
      end else begin
        mem[mem_addr[9:0]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sbq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.f});
        chk("latency", cyc, e.c);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic ef, input int lat,
                       input bit push);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    if (push) sbq.push_back('{rd: erd, f: ef, c: cyc + 1 + lat});
    last_acc = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int r0, w0, e0, c0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp", {resp_valid, resp_fault, mem_enable, mem_read}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);

    issue(0, 2'b00, 0, 32'h403, 0, 32'hFFFFFF88, 0, 2, 1);
    issue(0, 2'b00, 1, 32'h403, 0, 32'h00000088, 0, 2, 1);
    issue(0, 2'b01, 0, 32'h402, 0, 32'hFFFF8877, 0, 2, 1);
    issue(0, 2'b01, 1, 32'h400, 0, 32'h00006655, 0, 2, 1);
    issue(0, 2'b11, 0, 32'h400, 0, 32'h88776655, 0, 2, 1);
    drain();

    e0 = en_cnt;
`ifdef MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 32'h402, 0, 32'h0, 1, 1, 1);
    issue(0, 2'b01, 1, 32'h401, 0, 32'h0, 1, 1, 1);
    drain();
    chk("trap_no_mem", en_cnt - e0, 0);
`else
    issue(0, 2'b10, 0, 32'h402, 0, 32'h88776655, 0, 2, 1);
    issue(0, 2'b01, 1, 32'h401, 0, 32'h00006655, 0, 2, 1);
    drain();
    chk("mis_one_read_each", en_cnt - e0, 2);
`endif

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 2'b00, 0, 32'h401, 32'h123456AB, 32'h0, 0, 3, 1);
    drain();
    chk("sb_mem", mem[256], 32'h8877AB55);
    chk("sb_reads", rd_cnt - r0, 1);
    chk("sb_writes", wr_cnt - w0, 1);

    r0 = rd_cnt;
    issue(1, 2'b10, 0, 32'h404, 32'hDEADBEEF, 32'h0, 0, 1, 1);
    c0 = last_acc;
    issue(0, 2'b10, 0, 32'h404, 0, 32'hDEADBEEF, 0, 2, 1);
    chk("b2b_accept", last_acc, c0 + 2);
    drain();
    chk("sw_mem", mem[257], 32'hDEADBEEF);
    chk("sw_lw_reads", rd_cnt - r0, 1);

    issue(1, 2'b01, 0, 32'h406, 32'h55551234, 32'h0, 0, 3, 1);
    drain();
    chk("sh_mem", mem[257], 32'h1234BEEF);

    w0 = wr_cnt;
    issue(1, 2'b01, 0, 32'h402, 32'h0000CAFE, 32'h0, 0, 3, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_en", {31'b0, mem_enable}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_mid_mem", mem[256], 32'h8877AB55);
    chk("rst_mid_writes", wr_cnt - w0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
